// File: rtl/hwag_pkg.sv
// ---------------------------------------------------------------------------
// hwag_pkg
// Shared types and constants for the hardware angle generator (HWAG)
// synchronisation logic.
//   hwag_sync_state_t : sequencer state encoding (3 bits, exported on the
//                       debug 'state' port)
//   HWAG_FILL_EDGES   : crank edges spent in FILL before gap search starts,
//                       enough to prime the period-capture pipeline
//   HWAG_TCNT_WIDTH   : default tooth counter width
//   HWAG_GAP_LOAD     : default tooth index loaded on the gap edge
// ---------------------------------------------------------------------------
package hwag_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_EDGE = 3'd1,
    FILL      = 3'd2,
    SEARCH    = 3'd3,
    CONFIRM   = 3'd4,
    SYNC      = 3'd5
  } hwag_sync_state_t;

  localparam int unsigned HWAG_FILL_EDGES = 3;
  localparam int unsigned HWAG_TCNT_WIDTH = 6;
  localparam int unsigned HWAG_GAP_LOAD   = 2;

endpackage

// File: rtl/hwag_tooth_counter.sv
// ---------------------------------------------------------------------------
// hwag_tooth_counter
// Tooth index counter that wraps from tooth_top back to 0.
// Priority: clr > load > adv.
// Ports:
//   clk, rst   : clock, asynchronous active-low reset
//   clr        : synchronous clear to 0
//   load       : synchronous load of load_val
//   load_val   : value loaded when load=1
//   adv        : advance to the next tooth (nt)
//   tooth_top  : last tooth index of the wheel
//   tooth_cnt  : current tooth index
//   at_top     : tooth_cnt == tooth_top
//   nt         : next tooth index (0 after tooth_top)
// ---------------------------------------------------------------------------
module hwag_tooth_counter
  import hwag_pkg::*;
#(
  parameter int unsigned TCNT_WIDTH = HWAG_TCNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  load,
  input  logic [TCNT_WIDTH-1:0] load_val,
  input  logic                  adv,
  input  logic [TCNT_WIDTH-1:0] tooth_top,
  output logic [TCNT_WIDTH-1:0] tooth_cnt,
  output logic                  at_top,
  output logic [TCNT_WIDTH-1:0] nt
);

  assign at_top = (tooth_cnt == tooth_top);
  assign nt     = at_top ? '0 : tooth_cnt + TCNT_WIDTH'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tooth_cnt <= '0;
    end else if (clr) begin
      tooth_cnt <= '0;
    end else if (load) begin
      tooth_cnt <= load_val;
    end else if (adv) begin
      tooth_cnt <= nt;
    end
  end

endmodule

// File: rtl/hwag_sync_ctrl.sv
// ---------------------------------------------------------------------------
// hwag_sync_ctrl
// Synchronisation sequencer for the HWAG capture datapath. Walks
// IDLE -> WAIT_EDGE -> FILL -> SEARCH -> CONFIRM -> SYNC, owns the tooth
// counter and supervises loss of sync by counting consecutive gap mismatches.
// Ports:
//   clk        : clock, all state on rising edge
//   rst        : asynchronous active-low reset
//   enable     : 0 forces IDLE
//   edge_pulse : one-cycle strobe of the selected crank edge
//   pcnt_ovf   : period counter overflow (stall timeout)
//   gap_found  : gap comparator result, valid with edge_pulse
//   tooth_top  : last tooth index of the wheel (57 for 60-2)
//   pcnt_run   : period counter run enable
//   cap_ena    : period capture enable, low on the gap tooth once locked
//   hwag_start : high while in SYNC
//   tooth_cnt  : current tooth index
//   state      : encoded sequencer state (debug)
//   rev_pulse  : one-cycle pulse on the wrap edge in SYNC
//   sync_err   : one-cycle pulse per gap mismatch in SYNC
//   sync_lost  : one-cycle pulse when SYNC is abandoned
//   err_cnt    : consecutive mismatch count
// ---------------------------------------------------------------------------
module hwag_sync_ctrl
  import hwag_pkg::*;
#(
  parameter int unsigned TCNT_WIDTH  = HWAG_TCNT_WIDTH,
  parameter int unsigned GAP_LOAD    = HWAG_GAP_LOAD,
  parameter int unsigned CONFIRM_NUM = 1,
  parameter int unsigned ERR_WIDTH   = 3,
  parameter int unsigned ERR_MAX     = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  edge_pulse,
  input  logic                  pcnt_ovf,
  input  logic                  gap_found,
  input  logic [TCNT_WIDTH-1:0] tooth_top,
  output logic                  pcnt_run,
  output logic                  cap_ena,
  output logic                  hwag_start,
  output logic [TCNT_WIDTH-1:0] tooth_cnt,
  output logic [2:0]            state,
  output logic                  rev_pulse,
  output logic                  sync_err,
  output logic                  sync_lost,
  output logic [ERR_WIDTH-1:0]  err_cnt
);

  localparam int unsigned FILL_W = $clog2(HWAG_FILL_EDGES);
  localparam int unsigned CONF_W = $clog2(CONFIRM_NUM + 1);
  localparam logic [FILL_W-1:0]     FILL_LAST = FILL_W'(HWAG_FILL_EDGES - 1);
  localparam logic [CONF_W-1:0]     CONF_LAST = CONF_W'(CONFIRM_NUM);
  localparam logic [ERR_WIDTH-1:0]  ERR_LAST  = ERR_WIDTH'(ERR_MAX);
  localparam logic [TCNT_WIDTH-1:0] GAP_IDX   = TCNT_WIDTH'(GAP_LOAD);

  hwag_sync_state_t      state_q, state_d;
  logic [FILL_W-1:0]     fill_q, fill_d;
  logic [CONF_W-1:0]     conf_q, conf_d;
  logic [ERR_WIDTH-1:0]  err_d;
  logic                  run_d, rev_d, serr_d, lost_d;
  logic                  t_clr, t_load, t_adv;
  logic                  at_top;
  logic [TCNT_WIDTH-1:0] nt;
  logic                  exp_gap, gap_mismatch;

  hwag_tooth_counter #(
    .TCNT_WIDTH (TCNT_WIDTH)
  ) u_tooth (
    .clk       (clk),
    .rst       (rst),
    .clr       (t_clr),
    .load      (t_load),
    .load_val  (GAP_IDX),
    .adv       (t_adv),
    .tooth_top (tooth_top),
    .tooth_cnt (tooth_cnt),
    .at_top    (at_top),
    .nt        (nt)
  );

  // The tooth index is loaded with GAP_LOAD on the gap edge, so a correctly
  // placed gap is the edge whose advanced index lands on GAP_LOAD.
  assign exp_gap      = (nt == GAP_IDX);
  assign gap_mismatch = (gap_found != exp_gap);

  assign state      = state_q;
  assign hwag_start = (state_q == SYNC);
  // Suppress capture across the missing-tooth gap once the gap is located.
  assign cap_ena    = !(((state_q == CONFIRM) || (state_q == SYNC)) && at_top);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      fill_q    <= '0;
      conf_q    <= '0;
      err_cnt   <= '0;
      pcnt_run  <= 1'b0;
      rev_pulse <= 1'b0;
      sync_err  <= 1'b0;
      sync_lost <= 1'b0;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      conf_q    <= conf_d;
      err_cnt   <= err_d;
      pcnt_run  <= run_d;
      rev_pulse <= rev_d;
      sync_err  <= serr_d;
      sync_lost <= lost_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    conf_d  = conf_q;
    err_d   = err_cnt;
    run_d   = pcnt_run;
    rev_d   = 1'b0;
    serr_d  = 1'b0;
    lost_d  = 1'b0;
    t_clr   = 1'b0;
    t_load  = 1'b0;
    t_adv   = 1'b0;

    if (!enable) begin
      state_d = IDLE;
      run_d   = 1'b0;
      err_d   = '0;
      fill_d  = '0;
      conf_d  = '0;
      t_clr   = 1'b1;
    end else if (pcnt_ovf && (state_q inside {FILL, SEARCH, CONFIRM, SYNC})) begin
      // Wheel stalled: stop the period counter and wait for motion again.
      state_d = WAIT_EDGE;
      run_d   = 1'b0;
      err_d   = '0;
      fill_d  = '0;
      conf_d  = '0;
      t_clr   = 1'b1;
      lost_d  = (state_q == SYNC);
    end else begin
      case (state_q)
        IDLE: begin
          state_d = WAIT_EDGE;
        end
        WAIT_EDGE: begin
          if (edge_pulse) begin
            state_d = FILL;
            run_d   = 1'b1;
            fill_d  = '0;
          end
        end
        FILL: begin
          // Gap results are meaningless until the capture pipeline is primed.
          if (edge_pulse) begin
            if (fill_q == FILL_LAST) begin
              state_d = SEARCH;
              fill_d  = '0;
            end else begin
              fill_d = fill_q + FILL_W'(1);
            end
          end
        end
        SEARCH: begin
          if (edge_pulse && gap_found) begin
            state_d = CONFIRM;
            t_load  = 1'b1;
            conf_d  = '0;
          end
        end
        CONFIRM: begin
          if (edge_pulse) begin
            t_adv = 1'b1;
            if (gap_mismatch) begin
              state_d = SEARCH;
              t_clr   = 1'b1;
              conf_d  = '0;
            end else if (exp_gap) begin
              if ((conf_q + CONF_W'(1)) == CONF_LAST) begin
                state_d = SYNC;
                conf_d  = '0;
              end else begin
                conf_d = conf_q + CONF_W'(1);
              end
            end
          end
        end
        SYNC: begin
          // Flywheel: the index only advances, never reloads, so a single
          // spurious gap result cannot shift the angle reference.
          if (edge_pulse) begin
            t_adv = 1'b1;
            rev_d = at_top;
            if (gap_mismatch) begin
              serr_d = 1'b1;
              if ((err_cnt + ERR_WIDTH'(1)) == ERR_LAST) begin
                state_d = SEARCH;
                lost_d  = 1'b1;
                err_d   = '0;
                t_clr   = 1'b1;
              end else begin
                err_d = err_cnt + ERR_WIDTH'(1);
              end
            end else begin
              err_d = '0;
            end
          end
        end
        default: begin
          state_d = IDLE;
          run_d   = 1'b0;
          err_d   = '0;
          fill_d  = '0;
          conf_d  = '0;
          t_clr   = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hwag_sync_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hwag_sync_ctrl
// Scoreboard bench for hwag_sync_ctrl on a 60-2 wheel (tooth_top = 57).
// Stimulus pushes the expected output snapshot for a given cycle; the
// monitor pops and compares it on the falling edge of that cycle.
// Snapshot layout: {state[2:0], tooth[5:0], err[2:0], run, cap, start,
//                   rev, serr, lost}
// ---------------------------------------------------------------------------
module tb_hwag_sync_ctrl;

  localparam int S_IDLE = 0;
  localparam int S_WAIT = 1;
  localparam int S_FILL = 2;
  localparam int S_SRCH = 3;
  localparam int S_CONF = 4;
  localparam int S_SYNC = 5;
  localparam int TOP    = 57;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       edge_pulse;
  logic       pcnt_ovf;
  logic       gap_found;
  logic [5:0] tooth_top;
  logic       pcnt_run;
  logic       cap_ena;
  logic       hwag_start;
  logic [5:0] tooth_cnt;
  logic [2:0] state;
  logic       rev_pulse;
  logic       sync_err;
  logic       sync_lost;
  logic [2:0] err_cnt;

  hwag_sync_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .edge_pulse (edge_pulse),
    .pcnt_ovf   (pcnt_ovf),
    .gap_found  (gap_found),
    .tooth_top  (tooth_top),
    .pcnt_run   (pcnt_run),
    .cap_ena    (cap_ena),
    .hwag_start (hwag_start),
    .tooth_cnt  (tooth_cnt),
    .state      (state),
    .rev_pulse  (rev_pulse),
    .sync_err   (sync_err),
    .sync_lost  (sync_lost),
    .err_cnt    (err_cnt)
  );

  typedef struct {
    int          due;
    string       nm;
    logic [17:0] e;
  } item_t;

  item_t sb[$];
  int    cyc     = 0;
  int    n_total = 0;
  int    n_bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [17:0] ex(int st, int tooth, int err, bit rev, bit serr, bit lost);
    bit run;
    bit cap;
    bit start;
    run   = (st >= S_FILL) && (st <= S_SYNC);
    cap   = !(((st == S_CONF) || (st == S_SYNC)) && (tooth == TOP));
    start = (st == S_SYNC);
    return {3'(st), 6'(tooth), 3'(err), run, cap, start, rev, serr, lost};
  endfunction

  function automatic string fmt(logic [17:0] v);
    return $sformatf("st=%0d tooth=%0d err=%0d run=%b cap=%b start=%b rev=%b serr=%b lost=%b",
                     v[17:15], v[14:9], v[8:6], v[5], v[4], v[3], v[2], v[1], v[0]);
  endfunction

  task automatic push(input int due, input string nm, input logic [17:0] e);
    item_t it;
    it.due = due;
    it.nm  = nm;
    it.e   = e;
    sb.push_back(it);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Drive one cycle of inputs; expect snapshot e one cycle later and the same
  // snapshot with all pulses cleared the cycle after that.
  task automatic apply(input bit en, input bit ep, input bit gap, input bit ovf,
                       input string nm, input logic [17:0] e, input int idle);
    enable     = en;
    edge_pulse = ep;
    gap_found  = gap;
    pcnt_ovf   = ovf;
    push(cyc + 1, nm, e);
    push(cyc + 2, {nm, "_after"}, {e[17:3], 3'b000});
    step();
    edge_pulse = 1'b0;
    gap_found  = 1'b0;
    pcnt_ovf   = 1'b0;
    repeat (idle) step();
  endtask

  task automatic crank(input bit gap, input string nm, input logic [17:0] e);
    apply(1'b1, 1'b1, gap, 1'b0, nm, e, 9);
  endtask

  // From CONFIRM at tooth 2: 58 edges, gap only on the last one, ends in SYNC.
  task automatic confirm_rev();
    for (int k = 1; k <= 58; k++) begin
      crank(k == 58, "confirm", ex((k == 58) ? S_SYNC : S_CONF, (2 + k) % 58, 0, 0, 0, 0));
    end
  endtask

  always @(negedge clk) begin
    item_t       it;
    logic [17:0] act;
    while (sb.size() != 0 && sb[0].due <= cyc) begin
      it  = sb.pop_front();
      act = {state, tooth_cnt, err_cnt, pcnt_run, cap_ena, hwag_start,
             rev_pulse, sync_err, sync_lost};
      n_total++;
      if (act !== it.e) begin
        n_bad++;
        $display("FAIL %s @cyc%0d: got %s, need %s", it.nm, cyc, fmt(act), fmt(it.e));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst        = 1'b0;
    enable     = 1'b0;
    edge_pulse = 1'b0;
    pcnt_ovf   = 1'b0;
    gap_found  = 1'b0;
    tooth_top  = 6'(TOP);

    step();
    push(cyc, "reset", ex(S_IDLE, 0, 0, 0, 0, 0));
    step();
    rst = 1'b1;
    apply(1'b1, 1'b0, 1'b0, 1'b0, "en_wait", ex(S_WAIT, 0, 0, 0, 0, 0), 3);

    // Start-up: three fill edges after the first, then gap search.
    crank(1'b0, "edge1_run", ex(S_FILL, 0, 0, 0, 0, 0));
    crank(1'b0, "edge2_fill", ex(S_FILL, 0, 0, 0, 0, 0));
    crank(1'b1, "edge3_fill", ex(S_FILL, 0, 0, 0, 0, 0));
    crank(1'b0, "edge4_search", ex(S_SRCH, 0, 0, 0, 0, 0));
    crank(1'b0, "search_nogap", ex(S_SRCH, 0, 0, 0, 0, 0));
    crank(1'b1, "gap_edge", ex(S_CONF, 2, 0, 0, 0, 0));
    confirm_rev();

    // One clean revolution in SYNC: rev on the 57->0 edge, cap low at 57.
    for (int j = 1; j <= 58; j++) begin
      crank(j == 58, "sync_rev", ex(S_SYNC, (2 + j) % 58, 0, j == 56, 0, 0));
    end

    // Spurious gap landing on tooth 30.
    for (int j = 1; j <= 58; j++) begin
      crank((j == 28) || (j == 58), "spurious",
            ex(S_SYNC, (2 + j) % 58, (j == 28) ? 1 : 0, j == 56, j == 28, 0));
    end

    // Three consecutive mismatches lose sync.
    crank(1'b1, "mis1", ex(S_SYNC, 3, 1, 0, 1, 0));
    crank(1'b1, "mis2", ex(S_SYNC, 4, 2, 0, 1, 0));
    crank(1'b1, "mis3_lost", ex(S_SRCH, 0, 0, 0, 1, 1));

    // Relock, then stall with a coincident edge.
    crank(1'b1, "regap", ex(S_CONF, 2, 0, 0, 0, 0));
    confirm_rev();
    apply(1'b1, 1'b1, 1'b0, 1'b1, "ovf_edge", ex(S_WAIT, 0, 0, 0, 0, 1), 9);

    // enable=0 outranks pcnt_ovf.
    crank(1'b0, "ovf_restart", ex(S_FILL, 0, 0, 0, 0, 0));
    apply(1'b0, 1'b0, 1'b0, 1'b1, "dis_ovf", ex(S_IDLE, 0, 0, 0, 0, 0), 3);
    apply(1'b1, 1'b0, 1'b0, 1'b0, "reen", ex(S_WAIT, 0, 0, 0, 0, 0), 3);

    // Reach CONFIRM, then reset asynchronously between clock edges.
    crank(1'b0, "r_edge1", ex(S_FILL, 0, 0, 0, 0, 0));
    crank(1'b0, "r_edge2", ex(S_FILL, 0, 0, 0, 0, 0));
    crank(1'b0, "r_edge3", ex(S_FILL, 0, 0, 0, 0, 0));
    crank(1'b0, "r_edge4", ex(S_SRCH, 0, 0, 0, 0, 0));
    crank(1'b1, "r_gap", ex(S_CONF, 2, 0, 0, 0, 0));
    crank(1'b0, "r_conf", ex(S_CONF, 3, 0, 0, 0, 0));
    rst = 1'b0;
    push(cyc, "async_rst", ex(S_IDLE, 0, 0, 0, 0, 0));
    step();
    step();
    rst = 1'b1;
    apply(1'b1, 1'b0, 1'b0, 1'b0, "rel_wait", ex(S_WAIT, 0, 0, 0, 0, 0), 3);
    crank(1'b0, "rs_edge1", ex(S_FILL, 0, 0, 0, 0, 0));
    crank(1'b0, "rs_edge2", ex(S_FILL, 0, 0, 0, 0, 0));
    crank(1'b0, "rs_edge3", ex(S_FILL, 0, 0, 0, 0, 0));
    crank(1'b0, "rs_edge4", ex(S_SRCH, 0, 0, 0, 0, 0));

    repeat (5) step();
    n_total++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: pending=%0d required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/hwag_sync_ctrl.md
Name: hwag_sync_ctrl

Overview:
- Synchronisation sequencer for the hardware angle generator (HWAG) capture datapath.
- Consumes the selected crank edge strobe, the period-counter overflow and the gap-comparator result.
- Produces the start/capture controls for that datapath and owns the tooth counter.
- Walks through start, pipeline fill, gap search, gap confirmation and synced states, and supervises loss of sync by counting consecutive gap mismatches.

Parameters:
- TCNT_WIDTH, 6: width of tooth counter and tooth_top.
- GAP_LOAD, 2: tooth index loaded on the gap-detect edge (compensates capture pipeline lag).
- CONFIRM_NUM, 1: consecutive correctly placed gaps needed in CONFIRM before SYNC.
- ERR_WIDTH, 3: width of err_cnt.
- ERR_MAX, 3: consecutive mismatches in SYNC that declare sync lost; must satisfy ERR_MAX <= 2^ERR_WIDTH-1.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous active-low reset.
- enable  in  1  0 forces IDLE.
- edge_pulse  in  1  one-cycle strobe of the selected crank edge.
- pcnt_ovf  in  1  period counter overflow (stall timeout).
- gap_found  in  1  gap comparator result, valid in the edge_pulse cycle.
- tooth_top  in  TCNT_WIDTH  last tooth index (57 for 60-2); static while enable=1; must be > GAP_LOAD.
- pcnt_run  out  1  period counter run enable.
- cap_ena  out  1  period capture enable (combinational from state and tooth_cnt).
- hwag_start  out  1  high in SYNC.
- tooth_cnt  out  TCNT_WIDTH  current tooth index.
- state  out  3  encoded state, for debug.
- rev_pulse  out  1  one-cycle pulse on the wrap edge in SYNC.
- sync_err  out  1  one-cycle pulse per mismatch in SYNC.
- sync_lost  out  1  one-cycle pulse on SYNC to SEARCH.
- err_cnt  out  ERR_WIDTH  consecutive mismatch count.

Behaviour:
- Reset values: state=IDLE, all outputs 0, internal fill/confirm counters 0.
- All registered outputs update on the clk after the triggering cycle (1-cycle latency).
- Next tooth value nt = 0 if tooth_cnt==tooth_top, else tooth_cnt+1.
- An edge is "expected gap" iff nt==GAP_LOAD.
- Priority per cycle: enable=0 > pcnt_ovf > edge_pulse.
- enable=0 (any state): go to IDLE; clear pcnt_run, tooth_cnt, err_cnt, all counters.
- pcnt_ovf in any state other than IDLE/WAIT_EDGE: go to WAIT_EDGE, pcnt_run=0, tooth_cnt=0, err_cnt=0; sync_lost pulses if leaving SYNC.
- IDLE: enable=1 -> WAIT_EDGE.
- WAIT_EDGE: edge -> FILL; pcnt_run=1; fill_cnt=0.
- FILL: each edge increments fill_cnt; on the 3rd edge -> SEARCH. gap_found ignored.
- SEARCH: edge with gap_found=1 -> CONFIRM; tooth_cnt=GAP_LOAD; conf_cnt=0.
- CONFIRM, each edge tooth_cnt<=nt:
  - expected gap with gap_found=1: conf_cnt++; on reaching CONFIRM_NUM -> SYNC.
  - any mismatch (gap_found differs from expected): -> SEARCH, tooth_cnt=0.
- SYNC, each edge tooth_cnt<=nt (flywheel, never reloaded):
  - rev_pulse when tooth_cnt==tooth_top.
  - match: err_cnt=0.
  - mismatch: sync_err pulse, err_cnt++; if the new err_cnt==ERR_MAX -> SEARCH, sync_lost pulse, err_cnt=0, tooth_cnt=0.
- cap_ena = 0 iff state in {CONFIRM, SYNC} and tooth_cnt==tooth_top; otherwise 1. This suppresses capture across the missing-tooth gap.
- pcnt_run stays 1 in FILL, SEARCH, CONFIRM and SYNC.
- Illegal state encodings recover to IDLE.

Decomposition:
- Package hwag_pkg holds:
  - enum hwag_sync_state_t {IDLE, WAIT_EDGE, FILL, SEARCH, CONFIRM, SYNC} (3 bits).
  - Localparam HWAG_FILL_EDGES=3.
  - Default TCNT_WIDTH/GAP_LOAD constants shared with hwag_core.
- Sub-module hwag_tooth_counter: wrap-at-top counter with synchronous load and clear; outputs tooth_cnt, at_top and nt.

Test Plan:
- Start-up, 60-2 wheel: tooth_top=57; enable=1; edges every 10 clk; gap_found only on the model gap edge.
  - After edge 1: pcnt_run=1.
  - After edge 4: state=SEARCH.
  - Gap edge: tooth_cnt=2, state=CONFIRM.
  - 58 edges later: state=SYNC, hwag_start=1.
  - rev_pulse once every 58 edges.
- cap_ena: in SYNC with tooth_cnt=57, cap_ena=0; with tooth_cnt=0..56, cap_ena=1.
- Single spurious gap in SYNC at tooth 30: sync_err one pulse, err_cnt=1. The next correct gap gives err_cnt=0 and SYNC is held.
- Three consecutive mismatches in SYNC: err_cnt reaches 1, 2, then sync_lost pulses; state=SEARCH, tooth_cnt=0.
- Simultaneous events:
  - pcnt_ovf and edge_pulse in the same cycle while in SYNC -> WAIT_EDGE, pcnt_run=0, sync_lost=1.
  - enable=0 together with pcnt_ovf -> IDLE.
- Reset mid-operation: drive rst low asynchronously in CONFIRM -> all outputs 0 immediately, state=IDLE. After release, full resync is required (FILL counts 3 edges again).
